// File: rtl/serial_mult_pkg.sv
// Shared constants and helpers for the bit-serial truncating multiplier.
package serial_mult_pkg;

  localparam int NB_DATA_IN_DEFAULT  = 4;
  localparam int NB_DATA_OUT_DEFAULT = 2 * NB_DATA_IN_DEFAULT;

  // Width of the frame counter that walks bit positions 0..nb_data_in-1.
  function automatic int counter_width(input int nb_data_in);
    return $clog2(nb_data_in);
  endfunction

endpackage

// File: rtl/serial_mult_deser.sv
// Serial-to-parallel capture of one operand, LSB first, indexed by the frame counter.
module serial_mult_deser
  import serial_mult_pkg::*;
#(
  parameter int NB_DATA    = NB_DATA_IN_DEFAULT,
  parameter int NB_COUNTER = counter_width(NB_DATA_IN_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [NB_COUNTER-1:0] i_idx,
  input  logic                  i_data,
  output logic [NB_DATA-1:0]    o_word
);

  logic [NB_DATA-1:0] word;
  logic [NB_DATA-1:0] word_next;

  // o_word already contains the bit arriving on this edge, so the top can
  // multiply the completed operand on the last bit of the frame.
  always_comb begin
    // NOTE: default assignment first so every path drives word_next; no latch is inferred.
    word_next = word;
    for (int i = 0; i < NB_DATA; i++) begin
      if (i_idx == NB_COUNTER'(i)) word_next[i] = i_data;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so all flops update together.
    if (!i_rst)    word <= '0;
    else if (i_en) word <= word_next;
  end

  assign o_word = word_next;

endmodule

// File: rtl/serial_mult.sv
// Bit-serial multiplier emitting the upper half of each frame's product during the next frame.
// Define SERIAL_MULT_SIGNED_EN for two's-complement operands; unsigned otherwise.
module serial_mult
  import serial_mult_pkg::*;
#(
  parameter int NB_DATA_IN  = NB_DATA_IN_DEFAULT,
  parameter int NB_DATA_OUT = NB_DATA_OUT_DEFAULT
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_data_a,
  input  logic i_data_b,
  output logic o_data
);

  localparam int NB_COUNTER = counter_width(NB_DATA_IN);

  if (NB_DATA_OUT != 2 * NB_DATA_IN) begin : g_bad_out_width
    $error("serial_mult: NB_DATA_OUT must equal 2*NB_DATA_IN");
  end
  if (NB_DATA_IN < 2 || NB_DATA_IN > 32) begin : g_bad_in_width
    $error("serial_mult: NB_DATA_IN must be in 2..32");
  end

  logic [NB_COUNTER-1:0]  counter;
  logic                   last;
  logic [NB_DATA_IN-1:0]  a_full;
  logic [NB_DATA_IN-1:0]  b_full;
  logic [NB_DATA_OUT-1:0] product;
  logic [NB_DATA_IN-1:0]  product_hi;
  logic [NB_DATA_IN-1:0]  out_sr;

  assign last = (counter == NB_COUNTER'(NB_DATA_IN - 1));

  always_ff @(posedge clk) begin
    if (!i_rst)    counter <= '0;
    else if (i_en) counter <= last ? '0 : counter + 1'b1;
  end

  serial_mult_deser #(.NB_DATA(NB_DATA_IN), .NB_COUNTER(NB_COUNTER)) u_deser_a (
    .clk    (clk),
    .i_rst  (i_rst),
    .i_en   (i_en),
    .i_idx  (counter),
    .i_data (i_data_a),
    .o_word (a_full)
  );

  serial_mult_deser #(.NB_DATA(NB_DATA_IN), .NB_COUNTER(NB_COUNTER)) u_deser_b (
    .clk    (clk),
    .i_rst  (i_rst),
    .i_en   (i_en),
    .i_idx  (counter),
    .i_data (i_data_b),
    .o_word (b_full)
  );

  // Extending both operands to full width makes the low NB_DATA_OUT bits of
  // the product exact for either interpretation.
`ifdef SERIAL_MULT_SIGNED_EN
  assign product = {{NB_DATA_IN{a_full[NB_DATA_IN-1]}}, a_full}
                 * {{NB_DATA_IN{b_full[NB_DATA_IN-1]}}, b_full};
`else
  assign product = {{NB_DATA_IN{1'b0}}, a_full} * {{NB_DATA_IN{1'b0}}, b_full};
`endif

  assign product_hi = NB_DATA_IN'(product >> NB_DATA_IN);

  always_ff @(posedge clk) begin
    if (!i_rst)    out_sr <= '0;
    else if (i_en) out_sr <= last ? product_hi : {1'b0, out_sr[NB_DATA_IN-1:1]};
  end

  assign o_data = out_sr[0];

endmodule

// File: tb/tb_serial_mult.sv
// Self-checking bench for serial_mult; compile with SERIAL_MULT_SIGNED_EN for the signed build.
module tb_serial_mult;

  localparam int NB = 4;

  logic clk = 1'b0;
  logic i_rst;
  logic i_en;
  logic i_data_a;
  logic i_data_b;
  logic o_data;

  int n_checks = 0;
  int n_fail   = 0;
  logic [NB-1:0] exp_prev;

  serial_mult #(.NB_DATA_IN(NB), .NB_DATA_OUT(2 * NB)) dut (
    .clk      (clk),
    .i_rst    (i_rst),
    .i_en     (i_en),
    .i_data_a (i_data_a),
    .i_data_b (i_data_b),
    .o_data   (o_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Upper half of the product computed with plain integer arithmetic.
  function automatic logic [NB-1:0] ref_upper(input logic [NB-1:0] a, input logic [NB-1:0] b);
    int pa, pb, p;
`ifdef SERIAL_MULT_SIGNED_EN
    pa = a[NB-1] ? int'(a) - (1 << NB) : int'(a);
    pb = b[NB-1] ? int'(b) - (1 << NB) : int'(b);
`else
    pa = int'(a);
    pb = int'(b);
`endif
    p = pa * pb;
    return NB'((p & ((1 << (2 * NB)) - 1)) >> NB);
  endfunction

  // Streams one operand frame while checking the previous frame's result;
  // optionally stalls i_en for three cycles before bit stall_at.
  task automatic do_frame(input logic [NB-1:0] a, input logic [NB-1:0] b,
                          input logic [NB-1:0] exp_this, input int stall_at);
    for (int j = 0; j < NB; j++) begin
      if (j == stall_at) begin
        for (int s = 0; s < 3; s++) begin
          i_en     = 1'b0;
          i_data_a = 1'($urandom);
          i_data_b = 1'($urandom);
          @(negedge clk);
          check("stall_counter", 32'(dut.counter), 32'(j));
          check("stall_o_data", 32'(o_data), 32'(exp_prev[j]));
          @(posedge clk); #1;
        end
      end
      i_en     = 1'b1;
      i_data_a = a[j];
      i_data_b = b[j];
      @(negedge clk);
      check("counter", 32'(dut.counter), 32'(j));
      check("o_data", 32'(o_data), 32'(exp_prev[j]));
      @(posedge clk); #1;
    end
    exp_prev = exp_this;
  endtask

  initial begin
    logic [NB-1:0] ra, rb;

    i_rst = 1'b0; i_en = 1'b0; i_data_a = 1'b0; i_data_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_o_data", 32'(o_data), 32'd0);
    check("reset_counter", 32'(dut.counter), 32'd0);
    i_rst    = 1'b1;
    exp_prev = '0;

    // Directed corner operands with expected upper nibbles written out by hand.
`ifdef SERIAL_MULT_SIGNED_EN
    do_frame(4'b1000, 4'b0111, 4'hC, -1);
    do_frame(4'b1000, 4'b1000, 4'h4, -1);
    do_frame(4'b1111, 4'b0001, 4'hF, -1);
`else
    do_frame(4'b1000, 4'b1000, 4'h4, -1);
    do_frame(4'hF, 4'hF, 4'hE, -1);
    do_frame(4'd3, 4'd5, 4'h0, -1);
`endif

    // Stalled frame must produce the same result as the unstalled stream.
    ra = NB'($urandom);
    rb = NB'($urandom);
    do_frame(ra, rb, ref_upper(ra, rb), 2);
    do_frame(4'd0, 4'd0, 4'h0, 1);

    // Mid-frame reset at counter=2 discards operands and the pending result.
    ra = 4'hF;
    rb = 4'hF;
    do_frame(ra, rb, ref_upper(ra, rb), -1);
    for (int j = 0; j < 2; j++) begin
      i_en = 1'b1; i_data_a = 1'b1; i_data_b = 1'b1;
      @(negedge clk);
      check("pre_reset_o_data", 32'(o_data), 32'(exp_prev[j]));
      @(posedge clk); #1;
    end
    check("pre_reset_counter", 32'(dut.counter), 32'd2);
    i_rst = 1'b0;
    @(posedge clk); #1;
    check("mid_reset_o_data", 32'(o_data), 32'd0);
    check("mid_reset_counter", 32'(dut.counter), 32'd0);
    i_rst    = 1'b1;
    exp_prev = '0;

    for (int n = 0; n < 100; n++) begin
      ra = NB'($urandom);
      rb = NB'($urandom);
      do_frame(ra, rb, ref_upper(ra, rb), -1);
    end
    do_frame(4'd0, 4'd0, 4'h0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
